// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store,
// with one transaction outstanding and bounded LSU starvation of fetches.
module mem_arbiter #(
  parameter int XLEN          = 32,
  parameter int MAX_LSU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ifu_req,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [XLEN-1:0]   ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_write,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [XLEN/8-1:0] lsu_wstrb,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_LSU_BURST);

  state_t              state_reg;
  logic                owner_lsu_reg;
  logic                write_reg;
  logic [XLEN-1:0]     addr_reg;
  logic [XLEN-1:0]     wdata_reg;
  logic [XLEN/8-1:0]   wstrb_reg;
  logic [2:0]          lsu_streak_reg;

  logic grant_lsu;
  logic grant_ifu;
  logic idle_active;
  logic resp_hit;

  // LSU wins unless a waiting fetch has already been passed over MAX_LSU_BURST times.
  always_comb begin
    grant_lsu   = lsu_req && !(ifu_req && (lsu_streak_reg == STREAK_LIMIT));
    grant_ifu   = ifu_req && !grant_lsu;
    idle_active = (state_reg == IDLE) && !rst_b;
    resp_hit    = (state_reg == RESP) && bus_rvalid && !rst_b;
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_reg      <= IDLE;
      owner_lsu_reg  <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      lsu_streak_reg <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_lsu) begin
            owner_lsu_reg <= 1'b1;
            write_reg     <= lsu_write;
            addr_reg      <= lsu_addr;
            wdata_reg     <= lsu_wdata;
            wstrb_reg     <= lsu_wstrb;
            state_reg     <= REQ;
            if (ifu_req && (lsu_streak_reg != 3'd7))
              lsu_streak_reg <= lsu_streak_reg + 3'd1;
          end else if (grant_ifu) begin
            // Fetches are reads: write data and strobes are driven as zero.
            owner_lsu_reg  <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= ifu_addr;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            lsu_streak_reg <= 3'd0;
            state_reg      <= REQ;
          end
        end
        REQ: begin
          if (bus_ready)
            state_reg <= RESP;
        end
        RESP: begin
          if (bus_rvalid)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_ready  = idle_active && grant_ifu;
    lsu_ready  = idle_active && grant_lsu;
    ifu_rvalid = resp_hit && !owner_lsu_reg;
    lsu_rvalid = resp_hit && owner_lsu_reg;
    ifu_rdata  = ifu_rvalid ? bus_rdata : '0;
    lsu_rdata  = (lsu_rvalid && !write_reg) ? bus_rdata : '0;
    bus_req    = (state_reg == REQ) && !rst_b;
    bus_write  = write_reg && !rst_b;
    bus_addr   = rst_b ? '0 : addr_reg;
    bus_wdata  = rst_b ? '0 : wdata_reg;
    bus_wstrb  = rst_b ? '0 : wstrb_reg;
  end

endmodule
